// File: rtl/ahb_read_mux.sv
// AHB-Lite read-side mux for three slaves plus an internal default slave.
// Steers hrdata/hready/hresp from the slave owning the current data phase.
module ahb_read_mux (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [31:0] hrdata_1,
  input  logic [31:0] hrdata_2,
  input  logic [31:0] hrdata_3,
  input  logic        hreadyout_1,
  input  logic        hreadyout_2,
  input  logic        hreadyout_3,
  input  logic        hresp_1,
  input  logic        hresp_2,
  input  logic        hresp_3,
  output logic        hsel_1,
  output logic        hsel_2,
  output logic        hsel_3,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  typedef enum logic [2:0] {
    DS_NONE = 3'd0,
    DS_S1   = 3'd1,
    DS_S2   = 3'd2,
    DS_S3   = 3'd3,
    DS_DEF  = 3'd4
  } dsel_e;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dstate_e;

  dsel_e   dec;
  dsel_e   dsel_q, dsel_d;
  dstate_e dst_q, dst_d;
  logic    err_start;
  logic    def_ready, def_resp;

  // Address-phase decode; hsel stays live from haddr even in reset.
  always_comb begin
    dec = DS_DEF;
    case (haddr[31:28])
      4'h0:    dec = DS_S1;
      4'h1:    dec = DS_S2;
      4'h2:    dec = DS_S3;
      default: dec = DS_DEF;
    endcase
  end

  assign hsel_1 = (dec == DS_S1);
  assign hsel_2 = (dec == DS_S2);
  assign hsel_3 = (dec == DS_S3);

  // Data-phase owner only advances when the current data phase completes.
  always_comb begin
    dsel_d = dsel_q;
    if (hready) dsel_d = dec;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) dsel_q <= DS_NONE;
    else          dsel_q <= dsel_d;
  end

  // An active transfer accepted into the unmapped region starts an ERROR.
  assign err_start = hready && (dec == DS_DEF) && htrans[1];

  always_ff @(posedge hclk) begin
    if (!hresetn) dst_q <= D_IDLE;
    else          dst_q <= dst_d;
  end

  always_comb begin
    dst_d     = dst_q;
    def_ready = 1'b1;
    def_resp  = 1'b0;
    case (dst_q)
      D_IDLE: begin
        if (err_start) dst_d = D_ERR1;
      end
      D_ERR1: begin
        def_ready = 1'b0;
        def_resp  = 1'b1;
        dst_d     = D_ERR2;
      end
      D_ERR2: begin
        def_resp = 1'b1;
        dst_d    = err_start ? D_ERR1 : D_IDLE;
      end
      default: dst_d = D_IDLE;
    endcase
  end

  // Zero-latency response steering; hready depends only on registered state
  // and slave outputs, so there is no loop through the decode above.
  always_comb begin
    hrdata = 32'h0;
    hready = 1'b1;
    hresp  = 1'b0;
    case (dsel_q)
      DS_S1: begin
        hrdata = hrdata_1;
        hready = hreadyout_1;
        hresp  = hresp_1;
      end
      DS_S2: begin
        hrdata = hrdata_2;
        hready = hreadyout_2;
        hresp  = hresp_2;
      end
      DS_S3: begin
        hrdata = hrdata_3;
        hready = hreadyout_3;
        hresp  = hresp_3;
      end
      DS_DEF: begin
        hready = def_ready;
        hresp  = def_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ahb_read_mux.md
AHB_READ_MUX -- requirements
Module: ahb_read_mux

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: hclk and hresetn.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- hclk  in  1  bus clock
- hresetn  in  1  synchronous active-low reset
- haddr  in  32  address-phase address from the granted master (write-mux output)
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hrdata_1/2/3  in  32  slave read data
- hreadyout_1/2/3  in  1  slave ready
- hresp_1/2/3  in  1  slave response: 0 OKAY, 1 ERROR
- hsel_1/2/3  out  1  slave selects, combinational from haddr
- hrdata  out  32  read data to masters
- hready  out  1  bus-level ready, fed back to all slaves and masters
- hresp  out  1  bus-level response

Function
REQ-003 Address decode on haddr[31:28]: 0x0 selects slave 1; 0x1 selects slave 2; 0x2 selects slave 3; any other value selects the internal default slave (DEF).
REQ-004 hsel_n SHALL be combinational and one-hot or zero; hsel_1..3 SHALL all be 0 when DEF is decoded.
REQ-005 The data-phase select register dsel is one of NONE, S1, S2, S3, DEF; it SHALL load the decoded target only on a rising hclk edge where hready=1, and otherwise hold.
REQ-006 When dsel=Sn, the block SHALL drive hrdata=hrdata_n, hready=hreadyout_n and hresp=hresp_n combinationally, with zero added latency.
REQ-007 When dsel=NONE, the block SHALL drive hrdata=0, hready=1 and hresp=0.
REQ-008 When dsel=DEF, hrdata SHALL be 0 and the default-slave FSM SHALL drive hready and hresp.
REQ-009 The default-slave FSM states SHALL be D_IDLE, D_ERR1 and D_ERR2.
REQ-010 D_IDLE SHALL go to D_ERR1 on an hclk edge where hready=1, the decoded target is DEF and htrans[1]=1 (NONSEQ or SEQ); otherwise it SHALL stay in D_IDLE.
REQ-011 D_ERR1 SHALL always go to D_ERR2.
REQ-012 D_ERR2 SHALL go to D_ERR1 if the REQ-010 condition holds on that edge; otherwise it SHALL go to D_IDLE.
REQ-013 When dsel=DEF, the FSM SHALL drive outputs as follows:
- D_IDLE: hready=1, hresp=0 (zero-wait OKAY for IDLE or BUSY to an unmapped address)
- D_ERR1: hready=0, hresp=1
- D_ERR2: hready=1, hresp=1
This is the mandatory two-cycle AHB ERROR response.
REQ-014 Slave outputs are passed through on hready unchanged, including hready=0 wait states of any length. dsel SHALL NOT change during a wait state.
REQ-015 The block SHALL sample only haddr and htrans. hwrite and hwdata do not affect the response path; the write data path is owned by the write-side mux.
REQ-016 A pipelined back-to-back transfer to a different slave SHALL switch dsel on the edge that completes the current data phase, with no idle cycle inserted.
REQ-017 If all slave hready inputs are 1 and no master is granted (haddr=0, htrans=IDLE), dsel SHALL become S1 and hready SHALL follow hreadyout_1.

Reset
REQ-018 On an hclk edge with hresetn=0, the block SHALL set dsel=NONE and FSM=D_IDLE. The outputs SHALL then be hrdata=0, hready=1, hresp=0.
REQ-019 Reset asserted mid-wait-state or in D_ERR1/D_ERR2 SHALL abort the transfer and return the outputs to the REQ-018 values on the next edge.
REQ-020 hsel_n SHALL remain combinational from haddr during reset.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Read to 0x1000_0040, NONSEQ, slave 2 returns 0xDEADBEEF with hreadyout_2=1 -> hsel_2=1 in the address phase; next cycle hrdata=0xDEADBEEF, hready=1, hresp=0.
- Read to 0x0000_0000 with hreadyout_1 held 0 for 3 cycles -> hready=0 for 3 data-phase cycles; dsel holds S1; hrdata follows hrdata_1.
- NONSEQ to 0x7000_0000 -> following cycles show hready=0/hresp=1, then hready=1/hresp=1, then return to the next transfer.
- IDLE to 0x7000_0000 -> one data-phase cycle with hready=1, hresp=0, hrdata=0.
- Back-to-back NONSEQ 0x0000_0004 then 0x2000_0008 -> consecutive data phases return hrdata_1 then hrdata_3 with no gap.
- hresetn=0 during D_ERR1 -> next edge gives hready=1, hresp=0, hrdata=0, dsel=NONE.
